// File: rtl/uart.sv
// Memory-mapped 8N1 UART: TX FIFO feeding a serializer, deserializer feeding an RX FIFO.
// Registers: BAUD, CTRL, STATUS, TXDATA, RXDATA; optional level interrupt on pending RX data.
module uart #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] RST_DIV    = 16'd867
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    input  logic        rx_i,
    output logic        irq_o
);
    localparam int           AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    logic [2:0]  reg_sel;
    logic [15:0] baud_div;
    logic        tx_en, rx_en, rx_irq_en;
    logic        rx_overrun, frame_err;

    assign reg_sel = addr_i[4:2];

    logic unused_bus_bits;
    assign unused_bus_bits = ^{addr_i[31:5], addr_i[1:0], wdata_i[31:16], be_i[3:2]};

    logic wr_baud, wr_ctrl, wr_status;
    assign wr_baud   = we_i && (reg_sel == 3'd0);
    assign wr_ctrl   = we_i && (reg_sel == 3'd1);
    assign wr_status = we_i && (reg_sel == 3'd2) && be_i[0];

    // TX FIFO
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr;
    logic [AW:0]   tx_cnt;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = we_i && (reg_sel == 3'd3) && be_i[0] && !tx_full;

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wptr] <= wdata_i[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // TX serializer
    uart_state_t tx_state;
    logic [15:0] tx_bitcnt, tx_div;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_sh;
    logic        tx_bit_end, tx_busy;

    assign tx_bit_end = (tx_bitcnt == tx_div);
    assign tx_busy    = (tx_state != ST_IDLE);
    // The pop at the end of STOP is what makes back-to-back frames gapless.
    assign tx_pop     = tx_en && !tx_empty &&
                        ((tx_state == ST_IDLE) || (tx_state == ST_STOP && tx_bit_end));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state  <= ST_IDLE;
            tx_o      <= 1'b1;
            tx_bitcnt <= '0;
            tx_idx    <= '0;
        end else if (tx_pop) begin
            tx_state  <= ST_START;
            tx_o      <= 1'b0;
            tx_bitcnt <= '0;
            tx_idx    <= '0;
            tx_div    <= baud_div;
            tx_sh     <= tx_mem[tx_rptr];
        end else begin
            case (tx_state)
                ST_IDLE: tx_o <= 1'b1;
                ST_START: begin
                    if (tx_bit_end) begin
                        tx_state  <= ST_DATA;
                        tx_o      <= tx_sh[0];
                        tx_bitcnt <= '0;
                    end else begin
                        tx_bitcnt <= tx_bitcnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_bit_end) begin
                        tx_bitcnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx_state <= ST_STOP;
                            tx_o     <= 1'b1;
                        end else begin
                            tx_idx <= tx_idx + 3'd1;
                            tx_o   <= tx_sh[tx_idx + 3'd1];
                        end
                    end else begin
                        tx_bitcnt <= tx_bitcnt + 1'b1;
                    end
                end
                default: begin
                    if (tx_bit_end) tx_state  <= ST_IDLE;
                    else            tx_bitcnt <= tx_bitcnt + 1'b1;
                end
            endcase
        end
    end

    // RX synchronizer and deserializer
    logic        rx_s1, rx_s2, rx_s3;
    uart_state_t rx_state;
    logic [15:0] rx_bitcnt, rx_div;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_sh;
    logic        rx_fall, rx_bit_end, rx_half;
    logic        rx_stop_smp, rx_push_req, rx_push, rx_pop;
    logic        overrun_set, frame_set;

    assign rx_fall     = rx_s3 && !rx_s2;
    assign rx_bit_end  = (rx_bitcnt == rx_div);
    assign rx_half     = (rx_bitcnt == (rx_div >> 1));
    assign rx_stop_smp = rx_en && (rx_state == ST_STOP) && rx_bit_end;
    assign rx_push_req = rx_stop_smp && rx_s2;
    assign frame_set   = rx_stop_smp && !rx_s2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !rx_en) begin
            rx_state  <= ST_IDLE;
            rx_bitcnt <= '0;
            rx_idx    <= '0;
        end else begin
            case (rx_state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        rx_state  <= ST_START;
                        rx_bitcnt <= '0;
                        rx_div    <= baud_div;
                    end
                end
                ST_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (rx_half) begin
                        rx_state  <= rx_s2 ? ST_IDLE : ST_DATA;
                        rx_bitcnt <= '0;
                        rx_idx    <= '0;
                    end else begin
                        rx_bitcnt <= rx_bitcnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_bit_end) begin
                        rx_sh     <= {rx_s2, rx_sh[7:1]};
                        rx_bitcnt <= '0;
                        if (rx_idx == 3'd7) rx_state <= ST_STOP;
                        else                rx_idx   <= rx_idx + 3'd1;
                    end else begin
                        rx_bitcnt <= rx_bitcnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_bit_end) rx_state  <= ST_IDLE;
                    else            rx_bitcnt <= rx_bitcnt + 1'b1;
                end
            endcase
        end
    end

    // RX FIFO
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr, rx_rptr;
    logic [AW:0]   rx_cnt;
    logic          rx_full, rx_empty;

    assign rx_full     = (rx_cnt == FULL_CNT);
    assign rx_empty    = (rx_cnt == '0);
    assign rx_push     = rx_push_req && !rx_full;
    assign overrun_set = rx_push_req && rx_full;
    assign rx_pop      = re_i && (reg_sel == 3'd4) && !rx_empty;

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wptr] <= rx_sh;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // Configuration and sticky status; a hardware set beats a software clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            baud_div   <= RST_DIV;
            tx_en      <= 1'b0;
            rx_en      <= 1'b0;
            rx_irq_en  <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (wr_baud && be_i[0]) baud_div[7:0]  <= wdata_i[7:0];
            if (wr_baud && be_i[1]) baud_div[15:8] <= wdata_i[15:8];
            if (wr_ctrl && be_i[0]) {rx_irq_en, rx_en, tx_en} <= wdata_i[2:0];
            rx_overrun <= overrun_set || (rx_overrun && !(wr_status && wdata_i[5]));
            frame_err  <= frame_set   || (frame_err  && !(wr_status && wdata_i[6]));
        end
    end

    logic [6:0] status;
    assign status = {frame_err, rx_overrun, tx_busy, rx_empty, rx_full, tx_empty, tx_full};
    assign irq_o  = rx_irq_en && !rx_empty;

    always_comb begin
        rdata_o = '0;
        case (reg_sel)
            3'd0: rdata_o = {16'b0, baud_div};
            3'd1: rdata_o = {29'b0, rx_irq_en, rx_en, tx_en};
            3'd2: rdata_o = {25'b0, status};
            3'd4: rdata_o = {23'b0, !rx_empty, rx_empty ? 8'h00 : rx_mem[rx_rptr]};
            default: rdata_o = '0;
        endcase
    end
endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: directed timing checks plus randomized loopback
// traffic compared against byte queues and a count-based STATUS model.
module tb_uart;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, re = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        tx, irq;
    logic        loop = 1'b0;
    logic        rx_drv = 1'b1;
    logic        rx_line;

    int n_chk = 0;
    int n_pass = 0;

    localparam logic [4:0] A_BAUD = 5'h00, A_CTRL = 5'h04, A_STAT = 5'h08,
                           A_TXD = 5'h0C, A_RXD = 5'h10;

    assign rx_line = loop ? tx : rx_drv;

    uart #(.FIFO_DEPTH(8), .RST_DIV(16'd867)) dut (
        .clk_i(clk), .rst_i(rst), .we_i(we), .re_i(re), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
        .tx_o(tx), .rx_i(rx_line), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    endtask

    // STATUS derived from FIFO occupancies and flags.
    function automatic logic [31:0] exp_status(input int txn, input int rxn, input bit busy,
                                               input bit ovr, input bit fe);
        logic [31:0] s;
        s = '0;
        s[0] = (txn == 8);
        s[1] = (txn == 0);
        s[2] = (rxn == 8);
        s[3] = (rxn == 0);
        s[4] = busy;
        s[5] = ovr;
        s[6] = fe;
        return s;
    endfunction

    task automatic bus_wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        addr = {27'b0, off}; wdata = d; be = b; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; be = '0;
    endtask

    task automatic bus_rd(input logic [4:0] off, output logic [31:0] d);
        @(negedge clk);
        addr = {27'b0, off}; re = 1'b1;
        #1 d = rdata;
        @(posedge clk);
        #1;
        re = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
        logic bitv;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      bitv = 1'b0;
            else if (i == 9) bitv = stop;
            else             bitv = b[i-1];
            @(negedge clk) rx_drv = bitv;
            repeat (per - 1) @(negedge clk);
        end
        @(negedge clk) rx_drv = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  q[$];
        logic [7:0]  b;
        logic [9:0]  frame;
        int          div, n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Reset state
        bus_rd(A_STAT, d); check("reset_status", d, exp_status(0, 0, 0, 0, 0));
        bus_rd(A_BAUD, d); check("reset_baud", d, 32'h363);
        bus_rd(A_CTRL, d); check("reset_ctrl", d, 32'h0);
        bus_rd(A_TXD, d);  check("reset_txdata", d, 32'h0);
        bus_rd(A_RXD, d);  check("reset_rxdata", d, 32'h0);
        bus_rd(5'h14, d);  check("unmapped_read", d, 32'h0);
        check("reset_tx", {31'b0, tx}, 32'h1);
        check("reset_irq", {31'b0, irq}, 32'h0);

        // Byte-lane gating on BAUD
        bus_wr(A_BAUD, 32'hFFFF_AB07, 4'b0001);
        bus_rd(A_BAUD, d); check("baud_lane0", d, 32'h0307);
        bus_wr(A_BAUD, 32'hFFFF_12FF, 4'b0010);
        bus_rd(A_BAUD, d); check("baud_lane1", d, 32'h1207);

        // Exact TX waveform, DIV=3
        bus_wr(A_BAUD, 32'h3, 4'b0011);
        bus_wr(A_CTRL, 32'h1, 4'b0001);
        bus_wr(A_TXD, 32'hA5, 4'b0001);
        addr = {27'b0, A_STAT};
        check("tx_before_pop", {31'b0, tx}, 32'h1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                @(posedge clk);
                #1;
                check($sformatf("tx_bit%0d_c%0d", i, j), {31'b0, tx}, {31'b0, frame[i]});
                if (j == 0) check($sformatf("tx_busy_bit%0d", i), {31'b0, rdata[4]}, 32'h1);
            end
        end
        @(posedge clk);
        #1;
        check("tx_busy_end", {31'b0, rdata[4]}, 32'h0);
        check("tx_idle_end", {31'b0, tx}, 32'h1);

        // Loopback: 0x3C, 0xFF, 0x00 with interrupt
        loop = 1'b1;
        bus_wr(A_CTRL, 32'h7, 4'b0001);
        bus_wr(A_TXD, 32'h3C, 4'b0001);
        bus_wr(A_TXD, 32'hFF, 4'b0001);
        bus_wr(A_TXD, 32'h00, 4'b0001);
        for (int c = 0; c < 200 && !irq; c++) idle(1);
        check("irq_rise", {31'b0, irq}, 32'h1);
        idle(120);
        bus_rd(A_RXD, d); check("lb_rx0", d, 32'h13C);
        bus_rd(A_RXD, d); check("lb_rx1", d, 32'h1FF);
        check("irq_held", {31'b0, irq}, 32'h1);
        bus_rd(A_RXD, d); check("lb_rx2", d, 32'h100);
        check("irq_fall", {31'b0, irq}, 32'h0);
        bus_rd(A_RXD, d); check("lb_rx_empty", d, 32'h0);

        // Randomized loopback rounds
        for (int r = 0; r < 4; r++) begin
            div = $urandom_range(3, 9);
            n   = $urandom_range(1, 8);
            bus_wr(A_BAUD, div, 4'b0011);
            bus_rd(A_BAUD, d); check("rnd_baud", d, div);
            q.delete();
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                q.push_back(b);
                bus_wr(A_TXD, {24'b0, b}, 4'b0001);
            end
            idle(n * 10 * (div + 1) + 4 * (div + 1) + 10);
            bus_rd(A_STAT, d); check("rnd_status", d, exp_status(0, n, 0, 0, 0));
            for (int k = 0; k < n; k++) begin
                bus_rd(A_RXD, d); check($sformatf("rnd%0d_byte%0d", r, k), d, {23'b0, 1'b1, q[k]});
            end
            bus_rd(A_RXD, d); check("rnd_empty", d, 32'h0);
        end

        // TX FIFO overflow with TX disabled, then drain
        bus_wr(A_BAUD, 32'h3, 4'b0011);
        bus_wr(A_CTRL, 32'h2, 4'b0001);
        q.delete();
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom);
            q.push_back(b);
            bus_wr(A_TXD, {24'b0, b}, 4'b0001);
        end
        bus_rd(A_STAT, d); check("txfull_status", d, exp_status(8, 0, 0, 0, 0));
        bus_wr(A_CTRL, 32'h3, 4'b0001);
        idle(8 * 40 + 30);
        bus_rd(A_STAT, d); check("drain_status", d, exp_status(0, 8, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            bus_rd(A_RXD, d); check($sformatf("drain_byte%0d", k), d, {23'b0, 1'b1, q[k]});
        end
        bus_rd(A_RXD, d); check("drain_no_ninth", d, 32'h0);

        // RX overrun: 9 frames, no reads
        loop = 1'b0;
        bus_wr(A_CTRL, 32'h2, 4'b0001);
        q.delete();
        for (int k = 0; k < 9; k++) begin
            b = 8'($urandom);
            q.push_back(b);
            send_frame(b, 1'b1, 4);
        end
        idle(12);
        bus_rd(A_STAT, d); check("overrun_status", d, exp_status(0, 8, 0, 1, 0));
        for (int k = 0; k < 8; k++) begin
            bus_rd(A_RXD, d); check($sformatf("ovr_byte%0d", k), d, {23'b0, 1'b1, q[k]});
        end
        bus_wr(A_STAT, 32'h20, 4'b0001);
        bus_rd(A_STAT, d); check("overrun_clear", d, exp_status(0, 0, 0, 0, 0));

        // Framing error, glitch, then a good frame
        send_frame(8'($urandom), 1'b0, 4);
        idle(12);
        bus_rd(A_STAT, d); check("frame_err_status", d, exp_status(0, 0, 0, 0, 1));
        bus_rd(A_RXD, d);  check("frame_err_nopush", d, 32'h0);
        bus_wr(A_STAT, 32'h40, 4'b0001);
        bus_rd(A_STAT, d); check("frame_err_clear", d, exp_status(0, 0, 0, 0, 0));
        @(negedge clk) rx_drv = 1'b0;
        @(negedge clk) rx_drv = 1'b1;
        idle(20);
        bus_rd(A_STAT, d); check("glitch_status", d, exp_status(0, 0, 0, 0, 0));
        bus_rd(A_RXD, d);  check("glitch_nopush", d, 32'h0);
        b = 8'($urandom);
        send_frame(b, 1'b1, 4);
        idle(12);
        bus_rd(A_RXD, d);  check("post_glitch_byte", d, {23'b0, 1'b1, b});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart.md
# uart

Memory-mapped 8N1 UART peripheral occupying the UART slot of the data bus (data_addr_i[16]=1, data_addr_i[15:13]=3'b000). It has the same register-port shape as the other bus peripherals, with a TX FIFO feeding a serializer and a deserializer feeding an RX FIFO. The bus registers `rdata_o` one cycle after the access. An optional level interrupt flags pending RX data.

## Interface
- FIFO_DEPTH, 8, entries per FIFO; power of two, ≥2
- RST_DIV, 16'd867, reset value of the BAUD divisor (115200 baud at 100 MHz)
- clk_i  input  1  single clock
- rst_i  input  1  reset; **synchronous, active-high**
- we_i  input  1  write strobe; bus drives uart_en & data_we_i & data_req_i
- re_i  input  1  read strobe; bus drives uart_en & ~data_we_i & data_req_i
- be_i  input  4  byte enables for writes
- addr_i  input  32  byte address; only [4:2] decoded
- wdata_i  input  32  write data
- rdata_o  output  32  combinational read data for addr_i
- tx_o  output  1  serial out; idles high
- rx_i  input  1  serial in; asynchronous
- irq_o  output  1  RX-data-pending interrupt

## Operation
Register map (offset, addr_i[4:2]); each byte lane of a write is gated by be_i:
- 0x00 BAUD: RW, [15:0]=DIV, resets to RST_DIV. Bit period = DIV+1 cycles. DIV<3 is unsupported.
- 0x04 CTRL: RW, resets to 0.
  - [0]=tx_en, [1]=rx_en, [2]=rx_irq_en.
- 0x08 STATUS: read-only except the sticky bits.
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy.
  - [5] rx_overrun and [6] frame_err are sticky; writing 1 clears them.
- 0x0C TXDATA: a write with be_i[0] pushes wdata_i[7:0]. Reads return 0.
- 0x10 RXDATA: reads return {23'b0, valid, data[7:0]}.
  - valid=1 iff the RX FIFO was non-empty.
  - A read with re_i pops the head at the same clock edge.
  - A read when empty returns 0 and does not pop.
- Other offsets: read 0, writes ignored.

FIFO rules:
- Push is accepted only if the FIFO is not full at the start of the cycle; a pop in the same cycle does not free space.
- A push to a full TX FIFO is silently dropped.
- Simultaneous push and pop leave the count unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap; the count is one bit wider.

TX FSM: IDLE → START → DATA → STOP → (IDLE, or START if more data is queued).
- IDLE pops a byte when tx_en=1 and the FIFO is non-empty. DIV is latched at the pop.
- START drives tx_o=0 for one bit period.
- DATA sends 8 bits LSB first using a 3-bit index.
- STOP drives tx_o=1 for one bit period.
- Clearing tx_en mid-frame finishes the current frame; no further pops occur.

RX path:
- rx_i passes through a 2-flop synchronizer, both flops reset to 1.
- IDLE (rx_en=1): a 1→0 edge on the synchronized line goes to START, latching DIV.
- START: waits DIV>>1 cycles, then samples. Low → DATA. High → treat as a glitch and return to IDLE.
- DATA: samples every DIV+1 cycles, 8 bits, LSB first.
- STOP: samples once.
  - Stop=1: push the byte. If the FIFO is full, set rx_overrun and drop the byte.
  - Stop=0: set frame_err and discard the byte.
  - Then return to IDLE.
- rx_en=0 forces IDLE immediately; a partial byte is discarded.

irq_o = rx_irq_en & ~rx_empty (combinational from registers).

## Timing
Reset values:
- tx_o=1, irq_o=0; both FSMs in IDLE.
- FIFOs empty, so STATUS reads 0x0A (tx_empty, rx_empty).
- Sticky bits 0, CTRL=0, BAUD=RST_DIV.

TX timing:
- A TXDATA write at edge k enqueues.
- If TX is idle with tx_en=1, the pop happens at edge k+1 and tx_o=0 is visible after edge k+1.
- A frame is exactly 10·(DIV+1) cycles.
- Back-to-back frames have no idle gap.
- tx_busy is high from the pop until the last STOP cycle ends.

RX timing:
- A byte appears in the RX FIFO (rx_empty=0) one cycle after the STOP sample.
- The STOP sample falls at about 9.5 bit periods plus 2 synchronizer cycles after the start edge.

Register access:
- rdata_o is combinational; the pop happens at the same edge the bus captures rdata_o.
- A write to BAUD mid-frame takes effect at the next frame.
- Writing STATUS bits 5/6 in the same cycle the hardware sets them: the set wins.

## Test plan
- Reset, read all offsets: STATUS=0x0A, BAUD=0x363, CTRL=0, tx_o=1, irq_o=0.
- DIV=3, tx_en=1, write 0xA5:
  - tx_o low after 1 cycle.
  - Bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop.
  - tx_busy deasserts after 40 cycles.
- Loopback tx_o→rx_i, DIV=3, CTRL=0x7, send 0x3C, 0xFF, 0x00:
  - irq_o rises after the first byte.
  - RXDATA reads 0x13C, 0x1FF, 0x100, then 0x000.
  - irq_o falls after the third read.
- Write 10 bytes with tx_en=0 (FIFO_DEPTH=8): tx_full=1 and bytes 9–10 are dropped. Enable TX: exactly 8 frames are sent.
- Receive 9 frames with no reads: rx_overrun=1 and the first 8 bytes are intact. Write STATUS=0x20: rx_overrun=0.
- Inject a frame with stop=0 and, separately, a 1-cycle low glitch: frame_err=1 with no push for the bad frame; the glitch produces no effect.
